// File: rtl/cpa_pkg.sv
// Shared definitions for the carry-propagate adder: default width and word type.
package cpa_pkg;
    localparam int CPA_DEFAULT_WIDTH = 4;
    typedef logic [CPA_DEFAULT_WIDTH-1:0] cpa_word_t;
endpackage

// File: rtl/cpa_if.sv
// Operand/result bundle of the carry-propagate adder; master drives operands, slave returns sum.
interface cpa_if
    import cpa_pkg::*;
#(
    parameter int WIDTH = CPA_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (output a, output b, input  s, input  cout);
    modport slave  (input  a, input  b, output s, output cout);
endinterface

// File: rtl/cpa_full_adder.sv
// Single-bit full adder; one link of the ripple-carry chain.
module cpa_full_adder
    import cpa_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | ((a ^ b) & cin);
endmodule

// File: rtl/cpa.sv
// Ripple-carry adder with a registered sum/carry-out; result appears one clock after the operands.
module cpa
    import cpa_pkg::*;
#(
    parameter int WIDTH = CPA_DEFAULT_WIDTH
) (
    input logic   clk,
    input logic   rst,
    cpa_if.slave  bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_p0;
    logic [WIDTH-1:0] s_p1;
    logic             cout_p1;

    // Stage p0: combinational ripple chain, carry enters at zero.
    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        cpa_full_adder u_fa (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (c[i]),
            .sum  (sum_p0[i]),
            .cout (c[i+1])
        );
    end

    // Stage p1: output register; reset clears the result in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_p1    <= '0;
            cout_p1 <= 1'b0;
        end else begin
            s_p1    <= sum_p0;
            cout_p1 <= c[WIDTH];
        end
    end

    assign bus.s    = s_p1;
    assign bus.cout = cout_p1;
endmodule

// File: tb/tb_cpa.sv
// Scoreboard bench for cpa: directed, exhaustive and random operands against an arithmetic model.
module tb_cpa;
    import cpa_pkg::*;

    localparam int W = CPA_DEFAULT_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpa_if #(.WIDTH(W)) bus ();

    cpa #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [W:0]  exp_q[$];
    string       name_q[$];

    // Reference: unsigned sum in W+1 bits, or zero when reset is sampled.
    function automatic logic [W:0] model(input logic r, input cpa_word_t x, input cpa_word_t y);
        int unsigned total;
        total = int'(x) + int'(y);
        return r ? '0 : total[W:0];
    endfunction

    // Drive one operand pair for one edge, then record what that edge must produce.
    task automatic apply(input logic r, input cpa_word_t x, input cpa_word_t y, input string tag);
        rst   = r;
        bus.a = x;
        bus.b = y;
        @(posedge clk);
        exp_q.push_back(model(r, x, y));
        name_q.push_back(tag);
        #1;
    endtask

    // Monitor: result of each edge is compared on the following falling edge.
    initial begin
        logic [W:0] e;
        string      n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if ({bus.cout, bus.s} !== e) begin
                    errors++;
                    $display("FAIL %s: got cout=%b s=%h, expected cout=%b s=%h",
                             n, bus.cout, bus.s, e[W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        cpa_word_t x, y;
        bus.a = '0;
        bus.b = '0;

        apply(1'b1, 4'hF, 4'hF, "reset_edge0");
        apply(1'b1, 4'hF, 4'hF, "reset_edge1");

        apply(1'b0, 4'b0001, 4'b0010, "basic_add");
        apply(1'b0, 4'b1111, 4'b1010, "overflow0");
        apply(1'b0, 4'b0101, 4'b1100, "overflow1_b2b");
        apply(1'b0, 4'hF, 4'h1, "carry_all_stages");
        apply(1'b0, 4'h7, 4'h1, "carry_to_msb");
        apply(1'b0, 4'h0, 4'h0, "zero_plus_zero");
        apply(1'b0, 4'hF, 4'hF, "ones_plus_ones");
        apply(1'b0, 4'h9, 4'h9, "pre_reset");
        apply(1'b1, 4'h3, 4'h4, "midstream_reset");
        apply(1'b0, 4'h3, 4'h4, "after_reset");

        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                x = cpa_word_t'(i);
                y = cpa_word_t'(j);
                apply(1'b0, x, y, "exhaustive");
            end
        end

        for (int k = 0; k < 300; k++) begin
            x = cpa_word_t'($urandom_range(0, (1 << W) - 1));
            y = cpa_word_t'($urandom_range(0, (1 << W) - 1));
            apply(($urandom_range(0, 15) == 0), x, y, "random");
        end

        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
